t05_huff_decode: RTL and testbench

T05_HUFF_DECODE -- requirements
Module: t05_huff_decode

---
 rtl/t05_pkg.sv | 30 +++
 rtl/t05_hd_bitbuf.sv | 39 +++
 rtl/t05_huff_decode.sv | 141 ++++++++++++++
 tb/tb_t05_huff_decode.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/t05_pkg.sv
// Shared Huffman-decode definitions: FSM states and node field layout,
// also used by the codebook synthesizer that builds the tree image.
package t05_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    FETCH    = 3'd1,
    NEED_BIT = 3'd2,
    EMIT     = 3'd3,
    DONE     = 3'd4,
    ERR      = 3'd5
  } state_t;

  localparam logic [8:0] NULL_CHILD = 9'h180;
  localparam int NODE_W   = 71;
  localparam int LEFT_HI  = 63;
  localparam int LEFT_LO  = 55;
  localparam int RIGHT_HI = 54;
  localparam int RIGHT_LO = 46;

  // bit8 clear marks a leaf carrying its symbol in [7:0]
  function automatic logic is_leaf(input logic [8:0] c);
    return !c[8];
  endfunction

  function automatic logic is_null(input logic [8:0] c);
    return c == NULL_CHILD;
  endfunction

endpackage

// File: rtl/t05_hd_bitbuf.sv
// Byte-to-bit serializer: one byte plus a bit count, MSB shifted out first.
module t05_hd_bitbuf (
  input  logic       clk,
  input  logic       nrst,
  input  logic       flush,
  input  logic       enable,
  input  logic [7:0] byte_in,
  input  logic       byte_valid,
  output logic       byte_ready,
  input  logic       pop,
  output logic       bit_avail,
  output logic       bit_out
);

  logic [7:0] sh;
  logic [3:0] cnt;

  // loads only when empty and pops only when non-empty, so the two never collide
  assign byte_ready = enable && (cnt == 4'd0);
  assign bit_avail  = (cnt != 4'd0);
  assign bit_out    = sh[7];

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      sh  <= '0;
      cnt <= '0;
    end else if (flush) begin
      sh  <= '0;
      cnt <= '0;
    end else if (byte_ready && byte_valid) begin
      sh  <= byte_in;
      cnt <= 4'd8;
    end else if (pop && bit_avail) begin
      sh  <= {sh[6:0], 1'b0};
      cnt <= cnt - 4'd1;
    end
  end

endmodule

// File: rtl/t05_huff_decode.sv
// Huffman tree-walk decoder: fetches nodes on request, steers by one
// compressed bit per level and emits a symbol at each leaf.
module t05_huff_decode (
  input  logic        clk,
  input  logic        nrst,
  input  logic        start,
  input  logic [6:0]  max_index,
  input  logic [15:0] num_chars,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  output logic        byte_ready,
  output logic        tree_req,
  output logic [6:0]  tree_addr,
  input  logic        tree_ack,
  input  logic [70:0] h_element,
  output logic [7:0]  char_out,
  output logic        char_valid,
  input  logic        char_ready,
  output logic        busy,
  output logic        done,
  output logic        err
);

  import t05_pkg::*;

  state_t      st;
  logic [6:0]  root, node;
  logic [15:0] nchars, count;
  logic [8:0]  lchild, rchild, child;
  logic        ack_seen;
  logic        start_acc, pop, bit_avail, bit_out, flush;
  logic        unused_bits;

  assign unused_bits = ^{h_element[70:64], h_element[45:0]};

  assign start_acc = start && (st == IDLE || st == DONE || st == ERR);
  assign pop       = (st == NEED_BIT) && bit_avail;
  assign child     = bit_out ? rchild : lchild;
  assign flush     = start_acc || (st == DONE);
  assign tree_addr = tree_req ? node : 7'd0;

  t05_hd_bitbuf u_bitbuf (
    .clk        (clk),
    .nrst       (nrst),
    .flush      (flush),
    .enable     (busy),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .pop        (pop),
    .bit_avail  (bit_avail),
    .bit_out    (bit_out)
  );

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      st         <= IDLE;
      root       <= '0;
      node       <= '0;
      nchars     <= '0;
      count      <= '0;
      lchild     <= '0;
      rchild     <= '0;
      ack_seen   <= 1'b0;
      tree_req   <= 1'b0;
      char_out   <= '0;
      char_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      case (st)
        IDLE, DONE, ERR: begin
          if (start) begin
            root   <= max_index;
            node   <= max_index;
            nchars <= num_chars;
            count  <= '0;
            err    <= 1'b0;
            if (num_chars == 16'd0) begin
              st   <= DONE;
              done <= 1'b1;
            end else begin
              st       <= FETCH;
              done     <= 1'b0;
              busy     <= 1'b1;
              tree_req <= 1'b1;
              ack_seen <= 1'b0;
            end
          end
        end
        // children are captured on the ack; NEED_BIT follows one cycle later
        FETCH: begin
          if (ack_seen) begin
            ack_seen <= 1'b0;
            st       <= NEED_BIT;
          end else if (tree_ack) begin
            lchild   <= h_element[LEFT_HI:LEFT_LO];
            rchild   <= h_element[RIGHT_HI:RIGHT_LO];
            tree_req <= 1'b0;
            ack_seen <= 1'b1;
          end
        end
        NEED_BIT: begin
          if (bit_avail) begin
            if (is_null(child)) begin
              st   <= ERR;
              err  <= 1'b1;
              busy <= 1'b0;
            end else if (is_leaf(child)) begin
              char_out   <= child[7:0];
              char_valid <= 1'b1;
              st         <= EMIT;
            end else begin
              node     <= child[6:0];
              tree_req <= 1'b1;
              st       <= FETCH;
            end
          end
        end
        EMIT: begin
          if (char_ready) begin
            char_valid <= 1'b0;
            count      <= count + 16'd1;
            if (count + 16'd1 == nchars) begin
              st   <= DONE;
              done <= 1'b1;
              busy <= 1'b0;
            end else begin
              node     <= root;
              tree_req <= 1'b1;
              st       <= FETCH;
            end
          end
        end
        default: st <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_t05_huff_decode.sv
// Directed and random decode runs against a symbol-level reference.
module tb_t05_huff_decode;

  logic        clk = 0;
  logic        nrst = 1;
  logic        start = 0;
  logic [6:0]  max_index = '0;
  logic [15:0] num_chars = '0;
  logic [7:0]  byte_in = '0;
  logic        byte_valid = 0;
  logic        byte_ready;
  logic        tree_req;
  logic [6:0]  tree_addr;
  logic        tree_ack;
  logic [70:0] h_element;
  logic [7:0]  char_out;
  logic        char_valid;
  logic        char_ready = 0;
  logic        busy, done, err;

  always #5 clk = ~clk;

  t05_huff_decode dut (
    .clk(clk), .nrst(nrst), .start(start), .max_index(max_index),
    .num_chars(num_chars), .byte_in(byte_in), .byte_valid(byte_valid),
    .byte_ready(byte_ready), .tree_req(tree_req), .tree_addr(tree_addr),
    .tree_ack(tree_ack), .h_element(h_element), .char_out(char_out),
    .char_valid(char_valid), .char_ready(char_ready), .busy(busy),
    .done(done), .err(err)
  );

  // tree memory: answers a request after mem_delay waiting cycles
  logic [70:0] mem [128];
  int mem_delay = 0;
  int wait_cnt;
  always @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      tree_ack  <= 1'b0;
      h_element <= '0;
      wait_cnt  <= 0;
    end else if (tree_ack) begin
      tree_ack <= 1'b0;
      wait_cnt <= 0;
    end else if (tree_req) begin
      if (wait_cnt >= mem_delay) begin
        tree_ack  <= 1'b1;
        h_element <= mem[tree_addr];
      end else wait_cnt <= wait_cnt + 1;
    end
  end

  int n_assert = 0, n_fail = 0;
  logic [7:0] bq[$];
  logic [7:0] got[$];
  logic [7:0] exp_q[$];
  logic [7:0] sym_char[$];
  int sym_code[$], sym_len[$];
  int lat;
  bit saw_done, saw_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_child(input int addr, input int side, input logic [8:0] v);
    if (side == 0) mem[addr][63:55] = v;
    else           mem[addr][54:46] = v;
  endtask

  task automatic junk_node(input int addr);
    mem[addr] = 71'({$urandom, $urandom, $urandom});
  endtask

  // random full binary tree: repeatedly split a leaf slot into an internal node
  task automatic build_tree(input int k, input int base);
    int s_node[$], s_side[$], s_code[$], s_len[$];
    int r, nd, sd, cd, ln;
    for (int j = 0; j < k; j++) junk_node(base + j);
    s_node = {0, 0}; s_side = {0, 1}; s_code = {0, 1}; s_len = {1, 1};
    for (int j = 1; j < k; j++) begin
      r  = $urandom_range(0, s_node.size() - 1);
      nd = s_node[r]; sd = s_side[r]; cd = s_code[r]; ln = s_len[r];
      s_node.delete(r); s_side.delete(r); s_code.delete(r); s_len.delete(r);
      set_child(base + nd, sd, {2'b10, 7'(base + j)});
      s_node.push_back(j); s_side.push_back(0); s_code.push_back(cd << 1);     s_len.push_back(ln + 1);
      s_node.push_back(j); s_side.push_back(1); s_code.push_back((cd << 1) | 1); s_len.push_back(ln + 1);
    end
    sym_char.delete(); sym_code.delete(); sym_len.delete();
    for (int i = 0; i < s_node.size(); i++) begin
      set_child(base + s_node[i], s_side[i], {1'b0, 8'(8'h41 + i)});
      sym_char.push_back(8'(8'h41 + i));
      sym_code.push_back(s_code[i]);
      sym_len.push_back(s_len[i]);
    end
  endtask

  // drive one run until done/err or budget; collects emitted symbols into got
  task automatic run(input logic [6:0] root, input logic [15:0] n, input int stall_idx,
                     input int stall_len, input bit rnd, input bit chk_addr, input int budget);
    int cyc = 0;
    int stall = stall_len;
    bit holding = 0, pend = 0;
    logic [7:0] hold_c = '0;
    logic [6:0] paddr = '0;
    got.delete(); lat = -1; saw_done = 0; saw_err = 0;
    @(negedge clk); max_index = root; num_chars = n; start = 1;
    @(negedge clk); start = 0;
    while (cyc < budget) begin
      if (done) begin saw_done = 1; break; end
      if (err)  begin saw_err = 1;  break; end
      if (chk_addr && pend) begin
        chk("req_hold", 32'(tree_req), 1);
        chk("addr_hold", 32'(tree_addr), 32'(paddr));
      end
      pend = tree_req && !tree_ack; paddr = tree_addr;
      byte_valid = (bq.size() > 0) && (!rnd || $urandom_range(3) != 0);
      byte_in = byte_valid ? bq[0] : 8'($urandom);
      if (byte_valid && byte_ready) void'(bq.pop_front());
      if (char_valid && lat < 0) lat = cyc;
      char_ready = rnd ? ($urandom_range(2) != 0) : 1'b1;
      if (holding) begin
        chk("stall_valid", 32'(char_valid), 1);
        chk("stall_char", 32'(char_out), 32'(hold_c));
      end
      if (char_valid && got.size() == stall_idx && stall > 0) begin
        char_ready = 0; stall--;
        if (!holding) hold_c = char_out;
        holding = 1;
      end else holding = 0;
      if (char_valid && char_ready) got.push_back(char_out);
      @(negedge clk); cyc++;
    end
    byte_valid = 0; char_ready = 0;
    chk("run_end", 32'(saw_done | saw_err), 1);
  endtask

  task automatic load_abc();
    junk_node(2); junk_node(1);
    set_child(2, 0, {1'b0, 8'h41}); set_child(2, 1, 9'h101);
    set_child(1, 0, {1'b0, 8'h42}); set_child(1, 1, {1'b0, 8'h43});
    bq.delete(); bq.push_back(8'b0101_1000);
  endtask

  task automatic chk_abc(input string tag);
    chk({tag, "_done"}, 32'(saw_done), 1);
    chk({tag, "_cnt"}, 32'(got.size()), 3);
    if (got.size() == 3) begin
      chk({tag, "_A"}, 32'(got[0]), 32'h41);
      chk({tag, "_B"}, 32'(got[1]), 32'h42);
      chk({tag, "_C"}, 32'(got[2]), 32'h43);
    end
    chk({tag, "_busy"}, 32'(busy), 0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_req"}, 32'(tree_req), 0);
    chk({tag, "_addr"}, 32'(tree_addr), 0);
    chk({tag, "_br"}, 32'(byte_ready), 0);
    chk({tag, "_cv"}, 32'(char_valid), 0);
    chk({tag, "_co"}, 32'(char_out), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_err"}, 32'(err), 0);
  endtask

  initial begin
    int k, base, n, s, first_len, cyc;
    int bits[$];
    logic [7:0] b;

    #2 nrst = 0;
    #1 chk_all_zero("reset");
    repeat (2) @(negedge clk);
    nrst = 1;

    // basic three-symbol decode
    load_abc();
    run(7'd2, 16'd3, -1, 0, 0, 0, 500);
    chk_abc("abc");

    // consumer stalls on 'B'
    load_abc();
    run(7'd2, 16'd3, 1, 5, 0, 0, 500);
    chk_abc("stall");

    // slow tree memory: request must hold steady
    load_abc();
    mem_delay = 4;
    run(7'd2, 16'd3, -1, 0, 0, 1, 800);
    mem_delay = 0;
    chk_abc("slow");

    // single-leaf tree: bit 0 -> 'Z', bit 1 -> null child
    junk_node(5);
    set_child(5, 0, {1'b0, 8'h5A}); set_child(5, 1, 9'h180);
    bq.delete(); bq.push_back(8'b0100_0000);
    run(7'd5, 16'd3, -1, 0, 0, 0, 500);
    chk("leaf_cnt", 32'(got.size()), 1);
    if (got.size() > 0) chk("leaf_Z", 32'(got[0]), 32'h5A);
    chk("leaf_err", 32'(saw_err), 1);
    repeat (3) @(negedge clk);
    chk("leaf_err_hold", 32'(err), 1);
    chk("leaf_busy", 32'(busy), 0);
    chk("leaf_br", 32'(byte_ready), 0);

    // zero-length run
    @(negedge clk); max_index = 7'd2; num_chars = 16'd0; start = 1; byte_valid = 1;
    chk("zero_br0", 32'(byte_ready), 0);
    @(negedge clk); start = 0;
    chk("zero_br1", 32'(byte_ready), 0);
    @(negedge clk);
    chk("zero_done", 32'(done), 1);
    chk("zero_busy", 32'(busy), 0);
    chk("zero_err", 32'(err), 0);
    chk("zero_br2", 32'(byte_ready), 0);
    byte_valid = 0;

    // reset while a symbol is being offered
    load_abc();
    @(negedge clk); max_index = 7'd2; num_chars = 16'd3; start = 1;
    @(negedge clk); start = 0;
    cyc = 0;
    while (!char_valid && cyc < 100) begin
      byte_valid = bq.size() > 0;
      byte_in = byte_valid ? bq[0] : 8'h00;
      if (byte_valid && byte_ready) void'(bq.pop_front());
      @(negedge clk); cyc++;
    end
    byte_valid = 0;
    chk("rst_emit_reach", 32'(char_valid), 1);
    nrst = 0;
    #1 chk_all_zero("rst_mid");
    @(negedge clk); nrst = 1;
    load_abc();
    run(7'd2, 16'd3, -1, 0, 0, 0, 500);
    chk_abc("after_rst");

    // random trees, symbol streams, byte gaps and consumer back-pressure
    for (int t = 0; t < 6; t++) begin
      k = $urandom_range(1, 10);
      base = $urandom_range(0, 127 - k);
      build_tree(k, base);
      n = $urandom_range(1, 20);
      exp_q.delete(); bits.delete(); bq.delete();
      first_len = 0;
      for (int i = 0; i < n; i++) begin
        s = $urandom_range(0, sym_char.size() - 1);
        if (i == 0) first_len = sym_len[s];
        exp_q.push_back(sym_char[s]);
        for (int j = sym_len[s] - 1; j >= 0; j--) bits.push_back((sym_code[s] >> j) & 1);
      end
      for (int i = 0; i < bits.size(); i += 8) begin
        b = '0;
        for (int j = 0; j < 8; j++) if (i + j < bits.size()) b[7 - j] = bits[i + j][0];
        bq.push_back(b);
      end
      run(7'(base), 16'(n), -1, 0, 1, 0, 4000);
      chk("rnd_done", 32'(saw_done), 1);
      chk("rnd_cnt", 32'(got.size()), 32'(n));
      for (int i = 0; i < n && i < got.size(); i++) chk("rnd_char", 32'(got[i]), 32'(exp_q[i]));
      chk("rnd_lat", 32'(lat >= 3 * first_len + 1), 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
